sipo_deser: RTL
===============

# sipo_deser

Serial-in, parallel-out deserializer: the receive end of the 4-bit serial link driven by the team's parallel-in/serial-out shifter. It captures one serial bit per enabled clock, assembles `WIDTH`-bit words MSB-first or LSB-first, and presents each completed word on a registered output with a valid/ready handshake and a sticky overrun flag. It sits between the serial link and the parallel consumer logic.

## Interface
- `WIDTH`, default 4: word width in bits, legal range 2 to 32.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `sin`  in  1  serial data bit.
- `sin_en`  in  1  `sin` is captured on this clock when high.
- `lsb_first`  in  1  bit order: 0 means first bit received is dout MSB; 1 means first bit received is dout LSB.
- `clear`  in  1  synchronous frame abort.
- `dout_ready`  in  1  consumer accepts `dout` this cycle.
- `dout`  out  WIDTH  last completed word; held until overwritten.
- `dout_valid`  out  1  `dout` holds an unconsumed word.
- `busy`  out  1  frame in progress: at least one bit captured and word not yet complete.
- `bit_cnt`  out  $clog2(WIDTH)  bits captured in the current frame.
- `overrun`  out  1  sticky: a word completed while the previous one was still unconsumed.

## Operation
- States:
  - IDLE: `bit_cnt` is 0.
  - SHIFT: 0 < `bit_cnt` < WIDTH.
- IDLE to SHIFT on `sin_en`. In the same cycle, latch `lsb_first` into an internal `order` register for the whole frame.
- `lsb_first` changes mid-frame are ignored until the next frame starts.
- Shift on each `sin_en`:
  - order 0: `sr <= {sr[WIDTH-2:0], sin}`.
  - order 1: `sr <= {sin, sr[WIDTH-1:1]}`.
  - `bit_cnt` increments by 1.
- Gaps (`sin_en` low) hold `sr`, `bit_cnt` and state unchanged, with no timeout.
- Completion: `sin_en` high with `bit_cnt == WIDTH-1`.
  - `dout` takes the post-shift `sr` value.
  - `dout_valid` goes to 1.
  - `bit_cnt` goes to 0 and the state returns to IDLE.
- Handshake:
  - `dout_valid && dout_ready` with no completion in that cycle: `dout_valid` goes to 0.
  - Completion in the same cycle as acceptance: `dout` is replaced, `dout_valid` stays 1, and `overrun` is not set.
- Overrun: completion while `dout_valid == 1` and `dout_ready == 0`.
  - `dout` is overwritten with the new word.
  - `dout_valid` stays 1.
  - `overrun` goes to 1 and stays set.
- `clear`:
  - Forces `sr`, `bit_cnt` and `overrun` to 0 and the state to IDLE.
  - Overrides `sin_en` in the same cycle.
  - Leaves `dout` and `dout_valid` unchanged.
  - `dout_ready` is still honoured in that cycle.
- `busy` is 1 exactly in SHIFT.

## Timing
- Reset values:
  - `dout` = 0, `dout_valid` = 0, `busy` = 0, `bit_cnt` = 0, `overrun` = 0.
  - `sr` = 0, `order` = 0, state IDLE.
- Reset asserted mid-frame discards the partial word immediately (asynchronous). The first `sin_en` after reset release starts a new frame.
- Latency: `dout`/`dout_valid` update on the same edge that captures the last bit; they are visible the cycle after the last bit is presented.
- Back-to-back frames: the bit captured on the cycle after completion is bit 0 of the next frame. There are no dead cycles.
- Throughput: one word per WIDTH enabled cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `sipo_pkg` holds:
  - the state encoding (IDLE = 1'b0, SHIFT = 1'b1);
  - order constants `ORDER_MSB_FIRST` = 0 and `ORDER_LSB_FIRST` = 1.
- The block is a single module with no sub-module. The shift register, counter and output register are each one always block.

## Test plan
1. MSB-first, WIDTH = 4:
   - Stimulus: `sin` = 1,0,1,1 on 4 consecutive `sin_en` cycles.
   - Response: `dout` = 4'b1011, `dout_valid` = 1 one cycle after the 4th bit; `busy` 1 for cycles 2–4.
2. LSB-first, same bits 1,0,1,1:
   - Response: `dout` = 4'b1101.
   - Also toggle `lsb_first` after bit 2: result unchanged.
3. Gapped enable:
   - Stimulus: bits 0,1,1,0 with `sin_en` low 3 cycles between each.
   - Response: `dout` = 4'b0110; `bit_cnt` holds across gaps.
4. Overrun:
   - Stimulus: hold `dout_ready` = 0, send words 4'hA then 4'h5.
   - Response: `dout` = 4'h5, `dout_valid` = 1, `overrun` = 1.
   - Then assert `clear`: `overrun` = 0 and `dout` still 4'h5.
   - Variant: `dout_ready` = 1 on the completion cycle of word 2 gives `overrun` = 0.
5. Abort mid-frame:
   - Stimulus: 2 bits, then `clear` with `sin_en` high, then bits 1,1,1,1.
   - Response: `dout` = 4'hF, with no residue from the aborted frame.
   - Repeat using `rst` pulsed between clock edges instead of `clear`: all outputs go to 0 immediately.
6. Back-to-back:
   - Stimulus: 8 continuous bits 1,0,0,1,0,1,1,1 with `dout_ready` = 1.
   - Response: `dout` = 4'h9 then 4'h7 on consecutive word boundaries; `overrun` = 0.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-to-parallel deserializer: state encoding and bit-order codes.
package sipo_pkg;

   typedef enum logic {
      StIdle  = 1'b0,
      StShift = 1'b1
   } sipo_state_e;

   localparam logic ORDER_MSB_FIRST = 1'b0;
   localparam logic ORDER_LSB_FIRST = 1'b1;

endpackage

// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer with per-frame bit order, valid/ready output
// handshake and a sticky overrun flag.
module sipo_deser
   import sipo_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sin,
   input  logic                     sin_en,
   input  logic                     lsb_first,
   input  logic                     clear,
   input  logic                     dout_ready,
   output logic [WIDTH-1:0]         dout,
   output logic                     dout_valid,
   output logic                     busy,
   output logic [$clog2(WIDTH)-1:0] bit_cnt,
   output logic                     overrun
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   sipo_state_e      state_q, state_d;
   logic             order_q, order_d;
   logic [WIDTH-1:0] sr_q, sr_d, sr_shifted;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             cur_order;
   logic             complete;
   logic [WIDTH-1:0] dout_q;
   logic             valid_q;
   logic             overrun_q;

   // A new frame takes its order straight from the input; later bits use the latched copy.
   assign cur_order  = (state_q == StIdle) ? lsb_first : order_q;
   assign sr_shifted = (cur_order == ORDER_LSB_FIRST) ? {sin, sr_q[WIDTH-1:1]}
                                                      : {sr_q[WIDTH-2:0], sin};
   assign complete   = sin_en && !clear && (cnt_q == LastCnt);

   always_comb begin
      state_d = state_q;
      order_d = order_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      if (clear) begin
         state_d = StIdle;
         sr_d    = '0;
         cnt_d   = '0;
      end else if (sin_en) begin
         sr_d = sr_shifted;
         unique case (state_q)
            StIdle: begin
               state_d = StShift;
               order_d = lsb_first;
               cnt_d   = CntW'(1);
            end
            StShift: begin
               if (complete) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         order_q <= ORDER_MSB_FIRST;
      end else begin
         state_q <= state_d;
         order_q <= order_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Acceptance in the completion cycle frees the slot, so no overrun is flagged then.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (complete) begin
            dout_q  <= sr_shifted;
            valid_q <= 1'b1;
         end else if (valid_q && dout_ready) begin
            valid_q <= 1'b0;
         end
         if (clear) begin
            overrun_q <= 1'b0;
         end else if (complete && valid_q && !dout_ready) begin
            overrun_q <= 1'b1;
         end
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign busy       = (state_q == StShift);
   assign bit_cnt    = cnt_q;
   assign overrun    = overrun_q;

endmodule
